// File: rtl/cell_window_gen.sv
// 3x3 sliding-window generator: turns a raster pixel stream into one packed
// cell per interior pixel, centred on that pixel, over a valid/ready output.
module cell_window_gen #(
  parameter int CHANNEL_WIDTH = 8,
  parameter int CHANNEL_NUM   = 3,
  parameter int CELL_N        = 3,
  parameter int IMAGE_WIDTH   = 640,
  parameter int IMAGE_HEIGHT  = 480,
  localparam int PIXEL_W      = CHANNEL_WIDTH * CHANNEL_NUM,
  localparam int ROW_W        = $clog2(IMAGE_HEIGHT),
  localparam int COL_W        = $clog2(IMAGE_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [PIXEL_W-1:0]   pix_data,
  input  logic                 pix_sof,
  output logic                 cell_valid,
  input  logic                 cell_ready,
  output logic [PIXEL_W*9-1:0] cell_data,
  output logic [ROW_W-1:0]     cell_row,
  output logic [COL_W-1:0]     cell_col,
  output logic                 cell_last
);

  if (CELL_N != 3) begin : g_cell_n_check
    $error("cell_window_gen: only CELL_N == 3 is supported");
  end
  if (IMAGE_WIDTH < 3 || IMAGE_HEIGHT < 3) begin : g_image_size_check
    $error("cell_window_gen: image must be at least 3x3");
  end

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMAGE_WIDTH - 1);

  // lineA holds the previous line, lineB the one before it.
  logic [PIXEL_W-1:0] line_a [IMAGE_WIDTH];
  logic [PIXEL_W-1:0] line_b [IMAGE_WIDTH];

  // [dr][dc] packed so that flattening gives index 3*dr+dc, top-left in the LSBs.
  logic [2:0][2:0][PIXEL_W-1:0] win_q, win_d;

  logic [ROW_W-1:0]     row_q, row_d, cur_row;
  logic [COL_W-1:0]     col_q, col_d, cur_col;
  logic                 cell_valid_q, cell_valid_d;
  logic                 cell_last_q, cell_last_d;
  logic [PIXEL_W*9-1:0] cell_data_q, cell_data_d;
  logic [ROW_W-1:0]     cell_row_q, cell_row_d;
  logic [COL_W-1:0]     cell_col_q, cell_col_d;
  logic                 accept;
  logic                 emit;

  assign pix_ready = !cell_valid_q || cell_ready;
  assign accept    = pix_valid && pix_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would infer a latch.
    cur_row      = pix_sof ? '0 : row_q;
    cur_col      = pix_sof ? '0 : col_q;
    row_d        = row_q;
    col_d        = col_q;
    win_d        = win_q;
    emit         = 1'b0;
    cell_valid_d = cell_valid_q;
    cell_last_d  = cell_last_q;
    cell_data_d  = cell_data_q;
    cell_row_d   = cell_row_q;
    cell_col_d   = cell_col_q;

    if (accept) begin
      for (int dr = 0; dr < 3; dr++) begin
        for (int dc = 0; dc < 2; dc++) begin
          win_d[dr][dc] = win_q[dr][dc+1];
        end
      end
      win_d[0][2] = line_b[cur_col];
      win_d[1][2] = line_a[cur_col];
      win_d[2][2] = pix_data;

      if (cur_col == LAST_COL) begin
        col_d = '0;
        row_d = (cur_row == LAST_ROW) ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end

      emit         = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
      cell_valid_d = emit;
      cell_last_d  = emit && (cur_row == LAST_ROW) && (cur_col == LAST_COL);
      if (emit) begin
        cell_data_d = win_d;
        cell_row_d  = cur_row - ROW_W'(1);
        cell_col_d  = cur_col - COL_W'(1);
      end
    end else if (cell_ready) begin
      cell_valid_d = 1'b0;
      cell_last_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q        <= '0;
      col_q        <= '0;
      win_q        <= '0;
      cell_valid_q <= 1'b0;
      cell_last_q  <= 1'b0;
      cell_data_q  <= '0;
      cell_row_q   <= '0;
      cell_col_q   <= '0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      win_q        <= win_d;
      cell_valid_q <= cell_valid_d;
      cell_last_q  <= cell_last_d;
      cell_data_q  <= cell_data_d;
      cell_row_q   <= cell_row_d;
      cell_col_q   <= cell_col_d;
    end
  end

  // NOTE: line buffers are deliberately left out of reset so they map onto RAM;
  // every entry is rewritten before a cell can read it.
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      line_b[cur_col] <= line_a[cur_col];
      line_a[cur_col] <= pix_data;
    end
  end

  assign cell_valid = cell_valid_q;
  assign cell_last  = cell_last_q;
  assign cell_data  = cell_data_q;
  assign cell_row   = cell_row_q;
  assign cell_col   = cell_col_q;

endmodule

// File: tb/tb_cell_window_gen.sv
// Self-checking bench for cell_window_gen on a 5x4 image: per-cycle image
// model, table-driven order/packing checks and directed corner sequences.
module tb_cell_window_gen;

  localparam int W   = 5;
  localparam int H   = 4;
  localparam int PW  = 24;
  localparam int RWW = $clog2(H);
  localparam int CWW = $clog2(W);

  logic              clk = 1'b0;
  logic              reset;
  logic              pix_valid;
  logic              pix_ready;
  logic [PW-1:0]     pix_data;
  logic              pix_sof;
  logic              cell_valid;
  logic              cell_ready;
  logic [PW*9-1:0]   cell_data;
  logic [RWW-1:0]    cell_row;
  logic [CWW-1:0]    cell_col;
  logic              cell_last;

  cell_window_gen #(
    .CHANNEL_WIDTH(8), .CHANNEL_NUM(3), .CELL_N(3),
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)
  ) dut (
    .clk(clk), .reset(reset),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_sof(pix_sof),
    .cell_valid(cell_valid), .cell_ready(cell_ready), .cell_data(cell_data),
    .cell_row(cell_row), .cell_col(cell_col), .cell_last(cell_last)
  );

  always #5 clk = ~clk;

  typedef struct { logic [PW-1:0] data; logic sof; } beat_t;
  typedef struct { logic [PW*9-1:0] data; int row; int col; logic last; } cell_rec_t;
  typedef struct { int idx; int exp_row; int exp_col; logic exp_last; } order_vec_t;
  typedef struct { int idx; logic [7:0] exp_byte; } pack_vec_t;

  beat_t      src_q[$];
  cell_rec_t  log_q[$];
  order_vec_t order_tbl[6];
  pack_vec_t  pack_tbl[9];

  // Reference model: the image as a 2D array plus a raster position.
  logic [PW-1:0] img [H][W];
  int        m_r, m_c;
  bit        m_valid;
  cell_rec_t m_cell;

  int checks = 0;
  int errors = 0;
  int valid_pct = 100;
  int ready_pct = 100;

  bit              prev_stall = 0;
  logic [PW*9-1:0] prev_data;
  logic [RWW-1:0]  prev_row;
  logic [CWW-1:0]  prev_col;

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] pix(int r, int c);
    logic [7:0] b;
    b = 8'(r * 16 + c);
    return {3{b}};
  endfunction

  function automatic logic [PW*9-1:0] std_cell(int cr, int cc);
    logic [PW*9-1:0] d;
    d = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        d[(3*dr+dc)*PW +: PW] = pix(cr - 1 + dr, cc - 1 + dc);
    return d;
  endfunction

  task automatic push_frame(bit with_sof);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        src_q.push_back('{pix(r, c), with_sof && r == 0 && c == 0});
  endtask

  // One clock: drive at posedge+1, check and advance the model at negedge.
  task automatic step();
    bit exp_ready;
    int r, c;
    pix_valid = (src_q.size() > 0) && ($urandom_range(99) < valid_pct);
    if (pix_valid) begin
      pix_data = src_q[0].data;
      pix_sof  = src_q[0].sof;
    end else begin
      pix_data = PW'($urandom);
      pix_sof  = 1'($urandom);
    end
    cell_ready = ($urandom_range(99) < ready_pct);
    @(negedge clk);

    exp_ready = !m_valid || cell_ready;
    check("pix_ready", pix_ready, exp_ready);
    check("cell_valid", cell_valid, m_valid);
    if (m_valid) begin
      check("cell_data", cell_data, m_cell.data);
      check("cell_row", cell_row, m_cell.row);
      check("cell_col", cell_col, m_cell.col);
      check("cell_last", cell_last, m_cell.last);
    end
    if (prev_stall) begin
      check("stall_valid", cell_valid, 1);
      check("stall_data", cell_data, prev_data);
      check("stall_row", cell_row, prev_row);
      check("stall_col", cell_col, prev_col);
    end
    prev_stall = cell_valid && !cell_ready && !reset;
    prev_data  = cell_data;
    prev_row   = cell_row;
    prev_col   = cell_col;

    if (!reset && m_valid && cell_ready)
      log_q.push_back('{cell_data, int'(cell_row), int'(cell_col), cell_last});

    if (reset) begin
      m_valid = 0;
      m_r = 0;
      m_c = 0;
    end else if (pix_valid && exp_ready) begin
      r = pix_sof ? 0 : m_r;
      c = pix_sof ? 0 : m_c;
      img[r][c] = pix_data;
      void'(src_q.pop_front());
      m_valid = (r >= 2 && c >= 2);
      if (m_valid) begin
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            m_cell.data[(3*dr+dc)*PW +: PW] = img[r-2+dr][c-2+dc];
        m_cell.row  = r - 1;
        m_cell.col  = c - 1;
        m_cell.last = (r - 1 == H - 2) && (c - 1 == W - 2);
      end
      m_c = (c + 1) % W;
      m_r = (c == W - 1) ? (r + 1) % H : r;
    end else if (cell_ready) begin
      m_valid = 0;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((src_q.size() > 0 || m_valid) && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(n >= budget), 0);
  endtask

  task automatic run_to_first_cell(int budget);
    int n = 0;
    while (!m_valid && n < budget) begin
      step();
      n++;
    end
    check("first_cell_timeout", 32'(n >= budget), 0);
  endtask

  // Compares six logged cells of a standard frame against the order table.
  task automatic check_frame(int base, string tag);
    for (int i = 0; i < 6; i++) begin
      if (base + order_tbl[i].idx < log_q.size()) begin
        cell_rec_t rec = log_q[base + order_tbl[i].idx];
        check($sformatf("%s_row%0d", tag, i), rec.row, order_tbl[i].exp_row);
        check($sformatf("%s_col%0d", tag, i), rec.col, order_tbl[i].exp_col);
        check($sformatf("%s_last%0d", tag, i), rec.last, order_tbl[i].exp_last);
        check($sformatf("%s_data%0d", tag, i), rec.data,
              std_cell(order_tbl[i].exp_row, order_tbl[i].exp_col));
      end else begin
        check($sformatf("%s_missing%0d", tag, i), 1, 0);
      end
    end
  endtask

  initial begin
    order_tbl = '{'{0, 1, 1, 0}, '{1, 1, 2, 0}, '{2, 1, 3, 0},
                  '{3, 2, 1, 0}, '{4, 2, 2, 0}, '{5, 2, 3, 1}};
    pack_tbl  = '{'{0, 8'h11}, '{1, 8'h12}, '{2, 8'h13},
                  '{3, 8'h21}, '{4, 8'h22}, '{5, 8'h23},
                  '{6, 8'h31}, '{7, 8'h32}, '{8, 8'h33}};

    reset = 1'b1; pix_valid = 1'b0; pix_data = '0; pix_sof = 1'b0; cell_ready = 1'b0;
    m_valid = 0; m_r = 0; m_c = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cell_valid", cell_valid, 0);
    check("rst_cell_last", cell_last, 0);
    check("rst_cell_data", cell_data, 0);
    check("rst_cell_row", cell_row, 0);
    check("rst_cell_col", cell_col, 0);
    check("rst_pix_ready", pix_ready, 1);
    reset = 1'b0;

    // Full frame, continuous flow.
    log_q.delete();
    push_frame(1);
    drain(200);
    check("full_count", log_q.size(), 6);
    check_frame(0, "full");
    if (log_q.size() > 4) begin
      for (int i = 0; i < 9; i++)
        check($sformatf("pack_idx%0d", pack_tbl[i].idx),
              log_q[4].data[pack_tbl[i].idx*PW +: PW], {3{pack_tbl[i].exp_byte}});
    end else begin
      check("pack_missing", 1, 0);
    end

    // Backpressure: stall the first cell for five cycles.
    log_q.delete();
    push_frame(1);
    run_to_first_cell(100);
    ready_pct = 0;
    repeat (5) step();
    ready_pct = 100;
    drain(200);
    check("bp_count", log_q.size(), 6);
    check_frame(0, "bp");

    // Bubbles on both sides over three frames.
    log_q.delete();
    valid_pct = 50;
    ready_pct = 70;
    repeat (3) push_frame(1);
    drain(2000);
    valid_pct = 100;
    ready_pct = 100;
    check("bub_count", log_q.size(), 18);
    check_frame(0, "bub_f0");
    check_frame(6, "bub_f1");
    check_frame(12, "bub_f2");
    if (log_q.size() >= 12) begin
      for (int i = 0; i < 6; i++)
        check($sformatf("bub_repeat%0d", i), log_q[6+i].data, log_q[i].data);
    end

    // Resync: seven random pixels, then sof restarts the frame.
    log_q.delete();
    for (int i = 0; i < 7; i++) src_q.push_back('{PW'($urandom), 1'b0});
    push_frame(1);
    drain(200);
    check("sync_count", log_q.size(), 6);
    check_frame(0, "sync");

    // Reset while a cell is pending, then a clean frame without sof.
    log_q.delete();
    push_frame(1);
    run_to_first_cell(100);
    ready_pct = 0;
    step();
    check("pre_rst_valid", cell_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("post_rst_valid", cell_valid, 0);
    check("post_rst_ready", pix_ready, 1);
    ready_pct = 100;
    src_q.delete();
    log_q.delete();
    push_frame(0);
    drain(200);
    check("rst_frame_count", log_q.size(), 6);
    check_frame(0, "rst_frame");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/cell_window_gen.md
Name: cell_window_gen

Overview:
- Upstream neighbour of the cell processor. Accepts a raster-order pixel stream, one pixel_t per beat.
- Keeps two line buffers plus a 3x3 shift window and emits one full cell_t per interior pixel position, with that position as the centre pixel.
- Border pixels (first/last row and column) are never emitted as centres. Output is a valid/ready stream into the cell processor.

Parameters:
- CHANNEL_WIDTH, 8, bits per colour channel
- CHANNEL_NUM, 3, channels per pixel; PIXEL_W = CHANNEL_WIDTH*CHANNEL_NUM
- CELL_N, 3, cell edge; only 3 is supported (elaboration error otherwise)
- IMAGE_WIDTH, 640, pixels per line (>=3)
- IMAGE_HEIGHT, 480, lines per frame (>=3)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- pix_valid  in  1  input pixel valid
- pix_ready  out  1  block can accept a pixel this cycle
- pix_data  in  PIXEL_W  input pixel, raster order, left-to-right then top-to-bottom
- pix_sof  in  1  start of frame; qualified by a pixel handshake
- cell_valid  out  1  cell_data valid
- cell_ready  in  1  downstream accepts cell
- cell_data  out  PIXEL_W*9  packed cell, pixelMatrix layout
- cell_row  out  $clog2(IMAGE_HEIGHT)  row of centre pixel
- cell_col  out  $clog2(IMAGE_WIDTH)  column of centre pixel
- cell_last  out  1  final cell of frame

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - cell_valid=0, cell_last=0, cell_data=0, cell_row=0, cell_col=0.
  - Counters row=0, col=0.
  - Window registers cleared.
  - Line-buffer RAM contents are not reset; they are never observed before being rewritten.
- Ready: pix_ready = !cell_valid || cell_ready. This is a single output register skid-free scheme. Combinational in cell_ready only.
- Accept: a pixel is accepted when pix_valid && pix_ready. Nothing changes on a cycle with no accept, except that cell_valid clears when cell_ready=1.
- On accept at (row, col):
  - Column read: top = lineB[col], mid = lineA[col], bot = pix_data.
  - Line-buffer write: lineB[col] <= lineA[col]; lineA[col] <= pix_data.
  - Window shift: the window shifts left one column and {top, mid, bot} enters the right column.
- Cell emission:
  - If row>=2 && col>=2, the next cycle has cell_valid=1, cell_row=row-1, cell_col=col-1.
  - Latency is 1 cycle from accept to cell_valid.
  - If the condition fails, cell_valid goes to 0 when cell_ready, or holds per the ready rule.
- Packing: pixelMatrix[3*dr+dc], where dr, dc are in 0..2 measured from the top-left of the window. The centre is index 4 (centerPixel); index 0 holds the top-left pixel in the LSBs of cell_data.
- Counters:
  - col increments per accept and wraps at IMAGE_WIDTH-1 -> 0, incrementing row.
  - row wraps at IMAGE_HEIGHT-1 -> 0. The frame ends automatically with no gap needed.
- Resync: pix_sof=1 on an accepted pixel forces that pixel to be treated as (0,0). pix_sof without an accept is ignored.
- cell_last=1 exactly with the cell whose centre is (IMAGE_HEIGHT-2, IMAGE_WIDTH-2). It is 0 otherwise.
- Cells per frame: (IMAGE_HEIGHT-2)*(IMAGE_WIDTH-2). There is no padding or replication at borders.
- Stall: while cell_valid && !cell_ready, all outputs hold stable and pix_ready=0.
- Same-cycle events: output consume and a new accept in the same cycle loads the new cell (back-to-back throughput is 1 cell/cycle).
- Reset mid-frame: discards any pending cell. The next accepted pixel is (0,0), regardless of pix_sof.

Test Plan:
- Setup for all scenarios: IMAGE_WIDTH=5, IMAGE_HEIGHT=4, each pixel equals {row,col} replicated per channel (pixel = row*16+col per channel).
- Full frame, cell_ready=1, pix_valid=1 continuous:
  - Exactly 6 cells, centres (1,1),(1,2),(1,3),(2,1),(2,2),(2,3).
  - First cell_valid one cycle after accepting pixel (2,2).
  - cell_last only on (2,3).
- Cell packing: the cell centred (2,2) has index0=0x11, index4=0x22, index8=0x33 per channel, and all 9 entries match their (row,col).
- Backpressure: hold cell_ready=0 for 5 cycles on the first cell.
  - pix_ready=0 and cell_data/cell_row/cell_col stay stable.
  - After release the remaining cells arrive in order with none lost or duplicated.
- Bubbles: random pix_valid at 50% with cell_ready at 70% over 3 frames gives 18 cells with correct coordinates. Frame 2 cells are identical to frame 1.
- Resync: assert pix_sof at pixel index 7 mid-frame. Counting restarts, and the first cell after it is centred (1,1) with data from post-sof pixels.
- Reset: assert reset while cell_valid=1.
  - Next cycle cell_valid=0 and pix_ready=1.
  - A subsequent clean frame yields the 6 correct cells.
